// File: rtl/pipelined_datapath.sv
// Two-stage datapath: OF (regfile read, forwarding, B mux, barrel shift) then EX (ALU, writeback, flags).
// Latency: CwValid to ResultValid is 2 cycles, one control word accepted every cycle.
// Backpressure: none; every issued word completes, and CwValid=0 inserts a bubble.
module pipelined_datapath #(
  parameter int WIDTH     = 16,
  parameter int REG_COUNT = 8,
  parameter int ADDR_W    = 3,
  parameter int SHAMT_W   = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               CwValid,
  input  logic [ADDR_W-1:0]  DestAddr,
  input  logic [ADDR_W-1:0]  AAddr,
  input  logic [ADDR_W-1:0]  BAddr,
  input  logic               RegWrite,
  input  logic               MuxBConst,
  input  logic [WIDTH-1:0]   ConstB,
  input  logic [2:0]         ShiftOp,
  input  logic [SHAMT_W-1:0] ShiftAmt,
  input  logic [3:0]         FuncSel,
  input  logic               MuxDConst,
  input  logic [WIDTH-1:0]   ConstD,
  output logic               ResultValid,
  output logic [WIDTH-1:0]   Result,
  output logic               Overflow,
  output logic               CarryOut,
  output logic               Negative,
  output logic               Zero
);

  localparam logic [31:0] WIDTH_U = 32'(WIDTH);

  // Everything EX needs from OF travels as one pipeline word.
  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] dest;
    logic              reg_write;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [3:0]        func;
    logic              d_const;
    logic [WIDTH-1:0]  const_d;
  } ex_t;

  logic [WIDTH-1:0] regs [REG_COUNT];
  ex_t              ex;

  logic             fwd_ok;
  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] shifted_b;
  logic [31:0]      sh_amt;
  logic [31:0]      rot_amt;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH-1:0] alu;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH-1:0] d_val;

  // OF: operand read with EX-to-OF bypass on the D value, then B select.
  always_comb begin
    fwd_ok = ex.vld && ex.reg_write;
    a_op   = (fwd_ok && (ex.dest == AAddr)) ? d_val : regs[AAddr];
    b_op   = (fwd_ok && (ex.dest == BAddr)) ? d_val : regs[BAddr];
    sel_b  = MuxBConst ? ConstB : b_op;
  end

  // OF: barrel shifter; out-of-range amounts saturate for shifts and wrap for rotates.
  always_comb begin
    sh_amt  = 32'(ShiftAmt);
    rot_amt = sh_amt % WIDTH_U;
    shifted_b = sel_b;
    case (ShiftOp)
      3'b001: shifted_b = (sh_amt >= WIDTH_U) ? '0 : (sel_b << sh_amt);
      3'b010: shifted_b = (sh_amt >= WIDTH_U) ? '0 : (sel_b >> sh_amt);
      3'b011: shifted_b = (sh_amt >= WIDTH_U) ? {WIDTH{sel_b[WIDTH-1]}}
                                              : $unsigned($signed(sel_b) >>> sh_amt);
      // A shift by WIDTH yields 0, so rotate-by-zero falls out naturally.
      3'b100: shifted_b = (sel_b << rot_amt) | (sel_b >> (WIDTH_U - rot_amt));
      3'b101: shifted_b = (sel_b >> rot_amt) | (sel_b << (WIDTH_U - rot_amt));
      default: shifted_b = sel_b;
    endcase
  end

  // EX: arithmetic codes share one WIDTH+1 adder; logic codes bypass it with C=V=0.
  always_comb begin
    add_y   = '0;
    add_cin = 1'b0;
    case (ex.func[2:0])
      3'b001: add_cin = 1'b1;
      3'b010: add_y   = ex.b;
      3'b011: begin add_y = ex.b;  add_cin = 1'b1; end
      3'b100: add_y   = ~ex.b;
      3'b101: begin add_y = ~ex.b; add_cin = 1'b1; end
      3'b110: add_y   = '1;
      default: add_y  = '0;
    endcase
    sum = {1'b0, ex.a} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};

    alu   = sum[WIDTH-1:0];
    alu_c = sum[WIDTH];
    alu_v = (ex.a[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != ex.a[WIDTH-1]);
    if (ex.func[3]) begin
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (ex.func[2:0])
        3'b000:  alu = ex.a & ex.b;
        3'b001:  alu = ex.a | ex.b;
        3'b010:  alu = ex.a ^ ex.b;
        3'b011:  alu = ~ex.a;
        default: alu = ex.b;
      endcase
    end
    d_val = ex.d_const ? ex.const_d : alu;
  end

  // OF->EX pipeline register; reset drops any in-flight word.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ex <= '0;
    end else begin
      ex.vld       <= CwValid;
      ex.dest      <= DestAddr;
      ex.reg_write <= RegWrite;
      ex.a         <= a_op;
      ex.b         <= shifted_b;
      ex.func      <= FuncSel;
      ex.d_const   <= MuxDConst;
      ex.const_d   <= ConstD;
    end
  end

  // Register file writeback at the end of EX; never written while Reset is high.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (ex.vld && ex.reg_write) begin
      regs[ex.dest] <= d_val;
    end
  end

  // Result and flags update only for valid EX words, otherwise they hold.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ResultValid <= 1'b0;
      Result      <= '0;
      Overflow    <= 1'b0;
      CarryOut    <= 1'b0;
      Negative    <= 1'b0;
      Zero        <= 1'b0;
    end else begin
      ResultValid <= ex.vld;
      if (ex.vld) begin
        Result   <= d_val;
        Overflow <= alu_v;
        CarryOut <= alu_c;
        Negative <= alu[WIDTH-1];
        Zero     <= (alu == '0);
      end
    end
  end

endmodule

// File: tb/tb_pipelined_datapath.sv
// Self-checking bench: directed vector table, hand-written reset/bubble sequences, random words vs. an ISA-level model.
module tb_pipelined_datapath;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        CwValid;
  logic [2:0]  DestAddr, AAddr, BAddr;
  logic        RegWrite, MuxBConst, MuxDConst;
  logic [15:0] ConstB, ConstD;
  logic [2:0]  ShiftOp;
  logic [3:0]  ShiftAmt, FuncSel;
  logic        ResultValid;
  logic [15:0] Result;
  logic        Overflow, CarryOut, Negative, Zero;

  always #5 Clock = ~Clock;

  pipelined_datapath #(.WIDTH(16), .REG_COUNT(8), .ADDR_W(3), .SHAMT_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .CwValid(CwValid), .DestAddr(DestAddr),
    .AAddr(AAddr), .BAddr(BAddr), .RegWrite(RegWrite), .MuxBConst(MuxBConst),
    .ConstB(ConstB), .ShiftOp(ShiftOp), .ShiftAmt(ShiftAmt), .FuncSel(FuncSel),
    .MuxDConst(MuxDConst), .ConstD(ConstD), .ResultValid(ResultValid),
    .Result(Result), .Overflow(Overflow), .CarryOut(CarryOut),
    .Negative(Negative), .Zero(Zero)
  );

  typedef struct packed {
    logic        vld;
    logic [2:0]  dest, a, b;
    logic        rw, mbc;
    logic [15:0] cb;
    logic [2:0]  sop;
    logic [3:0]  samt, fs;
    logic        mdc;
    logic [15:0] cd;
  } cw_t;

  typedef struct packed {
    logic        rv;
    logic [15:0] res;
    logic [3:0]  vcnz;
  } exp_t;

  typedef struct {
    cw_t  cw;
    exp_t ex;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m_regs [8];
  vec_t        tbl [$];
  vec_t        seq [$];
  cw_t         idle = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, ".valid"}, 32'(ResultValid), 32'(e.rv));
    chk({tag, ".result"}, 32'(Result), 32'(e.res));
    chk({tag, ".vcnz"}, 32'({Overflow, CarryOut, Negative, Zero}), 32'(e.vcnz));
  endtask

  task automatic drive(input cw_t c);
    CwValid   = c.vld;  DestAddr = c.dest; AAddr    = c.a;   BAddr   = c.b;
    RegWrite  = c.rw;   MuxBConst = c.mbc; ConstB   = c.cb;  ShiftOp = c.sop;
    ShiftAmt  = c.samt; FuncSel  = c.fs;   MuxDConst = c.mdc; ConstD = c.cd;
  endtask

  function automatic cw_t w(input int dest, input int a, input int b, input int rw,
                            input int mbc, input int cb, input int sop, input int samt,
                            input int fs, input int mdc, input int cd);
    cw_t c;
    c.vld = 1'b1;        c.dest = 3'(dest); c.a = 3'(a);      c.b = 3'(b);
    c.rw = 1'(rw);       c.mbc = 1'(mbc);   c.cb = 16'(cb);   c.sop = 3'(sop);
    c.samt = 4'(samt);   c.fs = 4'(fs);     c.mdc = 1'(mdc);  c.cd = 16'(cd);
    return c;
  endfunction

  task automatic add(inout vec_t q[$], input cw_t c, input int res, input logic [3:0] f);
    vec_t v;
    v.cw = c;
    v.ex = '{rv: 1'b1, res: 16'(res), vcnz: f};
    q.push_back(v);
  endtask

  // Streams words back to back and checks each one two edges after issue.
  task automatic run_vecs(input string tag, input vec_t q[$]);
    for (int k = 0; k <= q.size(); k++) begin
      drive(k < q.size() ? q[k].cw : idle);
      @(posedge Clock); #1;
      if (k >= 1) check_out($sformatf("%s%0d", tag, k - 1), q[k-1].ex);
    end
  endtask

  // Architectural reference: words execute in program order on a register array.
  function automatic exp_t model(input cw_t c);
    exp_t e;
    int a, b, sh, y, cin, s, alu, sa, sy, ss, amt, r;
    logic v, cy;
    a   = int'(m_regs[c.a]);
    b   = c.mbc ? int'(c.cb) : int'(m_regs[c.b]);
    amt = int'(c.samt);
    r   = amt % 16;
    case (c.sop)
      3'd1:    sh = (amt >= 16) ? 0 : ((b << amt) & 'hFFFF);
      3'd2:    sh = (amt >= 16) ? 0 : (b >> amt);
      3'd3:    sh = (b >= 'h8000) ? ('hFFFF & ~(('hFFFF & ~b) >> amt)) : (b >> amt);
      3'd4:    sh = ((b << r) | (b >> (16 - r))) & 'hFFFF;
      3'd5:    sh = ((b >> r) | (b << (16 - r))) & 'hFFFF;
      default: sh = b;
    endcase
    if (c.fs < 8) begin
      case (c.fs)
        4'd1:    begin y = 0;                  cin = 1; end
        4'd2:    begin y = sh;                 cin = 0; end
        4'd3:    begin y = sh;                 cin = 1; end
        4'd4:    begin y = 'hFFFF & ~sh;       cin = 0; end
        4'd5:    begin y = 'hFFFF & ~sh;       cin = 1; end
        4'd6:    begin y = 'hFFFF;             cin = 0; end
        default: begin y = 0;                  cin = 0; end
      endcase
      s   = a + y + cin;
      alu = s & 'hFFFF;
      cy  = (s >= 'h10000);
      sa  = (a >= 'h8000) ? a - 'h10000 : a;
      sy  = (y >= 'h8000) ? y - 'h10000 : y;
      ss  = sa + sy + cin;
      v   = (ss > 32767) || (ss < -32768);
    end else begin
      case (c.fs)
        4'd8:    alu = a & sh;
        4'd9:    alu = a | sh;
        4'd10:   alu = a ^ sh;
        4'd11:   alu = 'hFFFF & ~a;
        default: alu = sh;
      endcase
      v  = 1'b0;
      cy = 1'b0;
    end
    e.rv   = 1'b1;
    e.res  = c.mdc ? c.cd : 16'(alu);
    e.vcnz = {v, cy, alu >= 'h8000, alu == 0};
    return e;
  endfunction

  initial begin
    exp_t zero_out, held, pend, e_now;
    cw_t  c;
    zero_out = '0;

    // Directed table: (dest, a, b, rw, mbc, cb, sop, samt, fs, mdc, cd) -> result, {V,C,N,Z}
    add(tbl, w(3,0,0,1,0,0,0,0,0,1,'h1234),      'h1234, 4'b0001);
    add(tbl, w(0,3,0,0,0,0,0,0,0,0,0),           'h1234, 4'b0000);
    add(tbl, w(1,0,0,1,0,0,0,0,0,1,'h0005),      'h0005, 4'b0001);
    add(tbl, w(2,1,1,1,0,0,0,0,2,0,0),           'h000A, 4'b0000);
    add(tbl, w(3,2,0,1,0,0,0,0,6,0,0),           'h0009, 4'b0100);
    add(tbl, w(4,0,0,1,0,0,0,0,0,1,'h7FFF),      'h7FFF, 4'b0001);
    add(tbl, w(0,4,0,0,1,1,0,0,2,0,0),           'h8000, 4'b1010);
    add(tbl, w(5,0,0,1,0,0,0,0,0,1,'hFFFF),      'hFFFF, 4'b0001);
    add(tbl, w(0,5,0,0,1,1,0,0,2,0,0),           'h0000, 4'b0101);
    add(tbl, w(0,0,0,0,1,'h8001,0,1,12,0,0),     'h8001, 4'b0010);
    add(tbl, w(0,0,0,0,1,'h8001,1,1,12,0,0),     'h0002, 4'b0000);
    add(tbl, w(0,0,0,0,1,'h8001,2,1,12,0,0),     'h4000, 4'b0000);
    add(tbl, w(0,0,0,0,1,'h8001,3,1,12,0,0),     'hC000, 4'b0010);
    add(tbl, w(0,0,0,0,1,'h8001,4,1,12,0,0),     'h0003, 4'b0000);
    add(tbl, w(0,0,0,0,1,'h8001,5,1,12,0,0),     'hC000, 4'b0010);
    add(tbl, w(0,0,0,0,1,'h8001,6,1,12,0,0),     'h8001, 4'b0010);
    add(tbl, w(0,0,0,0,1,'h8001,1,15,12,0,0),    'h8000, 4'b0010);
    add(tbl, w(0,0,0,0,1,'h8001,3,15,12,0,0),    'hFFFF, 4'b0010);
    add(tbl, w(0,0,0,0,1,'h8001,4,15,12,0,0),    'hC000, 4'b0010);
    add(tbl, w(0,0,0,0,1,'h8001,5,0,13,0,0),     'h8001, 4'b0010);
    add(tbl, w(6,0,0,1,0,0,0,0,0,1,'h00F0),      'h00F0, 4'b0001);
    add(tbl, w(7,0,0,1,0,0,0,0,0,1,'h000F),      'h000F, 4'b0001);
    add(tbl, w(0,6,7,0,0,0,0,0,9,0,0),           'h00FF, 4'b0000);
    add(tbl, w(6,6,0,1,0,0,0,0,1,0,0),           'h00F1, 4'b0000);
    add(tbl, w(0,6,7,0,0,0,0,0,8,0,0),           'h0001, 4'b0000);
    add(tbl, w(0,6,7,0,0,0,0,0,10,0,0),          'h00FE, 4'b0000);
    add(tbl, w(0,6,0,0,0,0,0,0,11,0,0),          'hFF0E, 4'b0010);
    add(tbl, w(0,6,7,0,0,0,0,0,5,0,0),           'h00E2, 4'b0100);
    add(tbl, w(0,6,7,0,0,0,0,0,4,0,0),           'h00E1, 4'b0100);
    add(tbl, w(0,6,7,0,0,0,0,0,3,0,0),           'h0101, 4'b0000);
    add(tbl, w(0,6,0,0,0,0,0,0,7,0,0),           'h00F1, 4'b0000);
    add(tbl, w(0,0,0,0,0,0,0,0,1,0,0),           'h0001, 4'b0000);
    add(tbl, w(0,0,6,0,0,0,1,4,12,0,0),          'h0F10, 4'b0000);
    add(tbl, w(0,4,0,0,1,'hFFFF,0,0,5,0,0),      'h8000, 4'b1010);
    add(tbl, w(0,0,0,0,0,0,0,0,6,0,0),           'hFFFF, 4'b0010);

    // Reset with a live word on the inputs: nothing may leak out.
    Reset = 1'b1;
    drive(w(3,0,0,1,0,0,0,0,0,1,'h1234));
    repeat (3) @(posedge Clock);
    #1;
    check_out("reset", zero_out);
    Reset = 1'b0;
    run_vecs("vec", tbl);

    // Bubbles: no valid, Result and flags hold the last word (0xFFFF, N=1).
    for (int i = 0; i < 3; i++) begin
      drive(idle);
      @(posedge Clock); #1;
      check_out($sformatf("bubble%0d", i), '{rv: 1'b0, res: 16'hFFFF, vcnz: 4'b0010});
    end

    // Reset clears the register file and outputs.
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    check_out("reset2", zero_out);
    Reset = 1'b0;
    seq.delete();
    add(seq, w(0,3,0,0,0,0,0,0,0,0,0), 'h0000, 4'b0001);
    add(seq, w(0,6,0,0,0,0,0,0,0,0,0), 'h0000, 4'b0001);
    run_vecs("clr", seq);

    // Reset during the EX cycle of a write to R4 discards it.
    drive(w(4,0,0,1,0,0,0,0,0,1,'h5555));
    @(posedge Clock); #1;
    Reset = 1'b1;
    drive(idle);
    @(posedge Clock); #1;
    check_out("midrst", zero_out);
    Reset = 1'b0;
    @(posedge Clock); #1;
    check_out("midrst_after", zero_out);
    seq.delete();
    add(seq, w(0,4,0,0,0,0,0,0,0,0,0), 'h0000, 4'b0001);
    run_vecs("r4", seq);

    // Random words against the architectural model.
    Reset = 1'b1;
    drive(idle);
    @(posedge Clock); #1;
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    held = '0;
    pend = '0;
    for (int k = 0; k <= 400; k++) begin
      c      = idle;
      c.dest = 3'($urandom_range(0, 7));
      c.a    = 3'($urandom_range(0, 7));
      c.b    = 3'($urandom_range(0, 7));
      c.rw   = 1'($urandom_range(0, 1));
      c.mbc  = 1'($urandom_range(0, 1));
      c.cb   = 16'($urandom);
      c.sop  = 3'($urandom_range(0, 7));
      c.samt = 4'($urandom_range(0, 15));
      c.fs   = 4'($urandom_range(0, 15));
      c.mdc  = ($urandom_range(0, 3) == 0);
      c.cd   = 16'($urandom);
      c.vld  = (k < 400) && ($urandom_range(0, 4) != 0);
      e_now  = '0;
      if (c.vld) begin
        e_now = model(c);
        if (c.rw) m_regs[c.dest] = e_now.res;
      end
      drive(c);
      @(posedge Clock); #1;
      if (k >= 1) begin
        if (pend.rv) held = pend;
        check_out($sformatf("rnd%0d", k - 1),
                  '{rv: pend.rv, res: held.res, vcnz: held.vcnz});
      end
      pend = e_now;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
